// File: rtl/load_store_unit_if.sv
// Execute-stage request, data-memory port and writeback response of the
// load-store unit, bundled so the unit and its environment share one view.
interface load_store_unit_if;
    // execute-stage request
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    // data-memory port
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    // writeback response
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        resp_err;
    logic        busy;

    // the load-store unit's own view
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
        input  mem_rdata, mem_ack,
        output req_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output resp_valid, resp_rdata, resp_rd, resp_err, busy
    );

    // the surrounding pipeline / memory view
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
        output mem_rdata, mem_ack,
        input  req_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  resp_valid, resp_rdata, resp_rd, resp_err, busy
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load-store unit: classifies an execute-stage access, runs one
// request/acknowledge transaction on the data-memory port with a timeout,
// and returns an extended load result or store completion to writeback.
module load_store_unit #(
    parameter int MAX_WAIT = 255   // legal range 1..255
) (
    input logic             clk,
    input logic             rst,
    load_store_unit_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state;
    logic [7:0]  wait_cnt;
    logic        lat_we;
    logic [2:0]  lat_funct3;
    logic [1:0]  lat_off;
    logic [4:0]  lat_rd;

    logic        dec_bad;
    logic [3:0]  dec_be;
    logic [31:0] dec_wdata;
    logic [31:0] shifted;
    logic [31:0] load_data;

    assign bus.req_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);

    // Classify the incoming request and build its byte enables / store lanes.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        dec_bad   = 1'b0;
        dec_be    = 4'b1111;
        dec_wdata = bus.req_wdata;
        if (bus.req_we)
            dec_bad = (bus.req_funct3 > 3'b010);
        else
            dec_bad = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11);
        case (bus.req_funct3[1:0])
            2'b00: begin
                dec_be    = 4'b0001 << bus.req_addr[1:0];
                dec_wdata = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                dec_be    = 4'b0011 << bus.req_addr[1:0];
                dec_wdata = {2{bus.req_wdata[15:0]}};
                if (bus.req_addr[0]) dec_bad = 1'b1;
            end
            default: begin
                if (bus.req_addr[1:0] != 2'b00) dec_bad = 1'b1;
            end
        endcase
    end

    // Align the returned word to the accessed byte lane and extend it.
    always_comb begin
        shifted = bus.mem_rdata >> {lat_off, 3'b000};
        case (lat_funct3)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_data = {24'h0, shifted[7:0]};
            3'b101:  load_data = {16'h0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    // Control FSM with registered memory-port and response outputs.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register updating from
        // pre-edge values, independent of statement order.
        if (rst) begin
            state          <= IDLE;
            wait_cnt       <= '0;
            lat_we         <= 1'b0;
            lat_funct3     <= '0;
            lat_off        <= '0;
            lat_rd         <= '0;
            bus.mem_req    <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            bus.mem_be     <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_rd    <= '0;
            bus.resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        lat_we     <= bus.req_we;
                        lat_funct3 <= bus.req_funct3;
                        lat_off    <= bus.req_addr[1:0];
                        lat_rd     <= bus.req_rd;
                        if (dec_bad) begin
                            // rejected without touching memory
                            state          <= RESP;
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b1;
                        end else begin
                            state         <= ACCESS;
                            wait_cnt      <= '0;
                            bus.mem_req   <= 1'b1;
                            bus.mem_we    <= bus.req_we;
                            bus.mem_addr  <= {bus.req_addr[31:2], 2'b00};
                            bus.mem_be    <= dec_be;
                            bus.mem_wdata <= bus.req_we ? dec_wdata : 32'h0;
                        end
                    end
                end
                ACCESS: begin
                    if (bus.mem_ack || wait_cnt == 8'(MAX_WAIT - 1)) begin
                        // an ack in the last allowed cycle still wins
                        state          <= RESP;
                        bus.mem_req    <= 1'b0;
                        bus.mem_we     <= 1'b0;
                        bus.mem_addr   <= '0;
                        bus.mem_wdata  <= '0;
                        bus.mem_be     <= '0;
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= !bus.mem_ack;
                        if (bus.mem_ack && !lat_we) begin
                            bus.resp_rdata <= load_data;
                            bus.resp_rd    <= lat_rd;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    state          <= IDLE;
                    bus.resp_valid <= 1'b0;
                    bus.resp_rdata <= '0;
                    bus.resp_rd    <= '0;
                    bus.resp_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// accesses compared against an arithmetic reference model.
module tb_load_store_unit;

    localparam int MAXW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    load_store_unit_if bus ();

    load_store_unit #(.MAX_WAIT(MAXW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit ref_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        int size;
        bit legal;
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal) return 1'b1;
        size = 1 << f3[1:0];
        return (addr % size) != 0;
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] addr);
        int bytes;
        int m;
        bytes = 1 << f3[1:0];
        m = ((1 << bytes) - 1) << (addr % 4);
        return 4'(m);
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[7:0];
        h = w[15:0];
        case (f3)
            3'd0:    return 32'(b) * 32'h0101_0101;
            3'd1:    return 32'(h) * 32'h0001_0001;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        longint unsigned v;
        int  bits;
        bit  sgn;
        bits = (f3 == 3'd2) ? 32 : ((f3[0]) ? 16 : 8);
        sgn  = (f3 == 3'd0) || (f3 == 3'd1);
        v = longint'(rdata) >> (8 * (addr % 4));
        v = v % (64'd1 << bits);
        if (sgn && v >= (64'd1 << (bits - 1))) v = v - (64'd1 << bits);
        return 32'(v);
    endfunction

    // Scramble request fields while the unit is busy; it must ignore them.
    task automatic scramble_req();
        bus.req_valid  = 1'($urandom);
        bus.req_we     = 1'($urandom);
        bus.req_funct3 = 3'($urandom);
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
        bus.req_rd     = 5'($urandom);
    endtask

    // One full access. ack_at: ACCESS cycle index (0-based) carrying mem_ack,
    // or -1 for no ack at all.
    task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [4:0] rd,
                             input int ack_at, input logic [31:0] rdata);
        bit err;
        bit acked;
        err   = ref_err(we, f3, addr);
        acked = 1'b0;
        @(negedge clk);
        check("req_ready", 32'(bus.req_ready), 32'd1);
        check("idle_resp_valid", 32'(bus.resp_valid), 32'd0);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_rd     = rd;
        bus.mem_ack    = 1'($urandom);   // ignored while idle
        bus.mem_rdata  = $urandom;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        if (err) begin
            bus.req_valid = 1'b0;
            check("err_mem_req", 32'(bus.mem_req), 32'd0);
            check("err_resp_valid", 32'(bus.resp_valid), 32'd1);
            check("err_resp_err", 32'(bus.resp_err), 32'd1);
            check("err_resp_rdata", bus.resp_rdata, 32'd0);
            check("err_resp_rd", 32'(bus.resp_rd), 32'd0);
            return;
        end
        for (int k = 0; k < MAXW && !acked; k++) begin
            check("mem_req", 32'(bus.mem_req), 32'd1);
            check("mem_we", 32'(bus.mem_we), 32'(we));
            check("mem_addr", bus.mem_addr, addr & ~32'h3);
            check("mem_be", 32'(bus.mem_be), 32'(ref_be(f3, addr)));
            if (we) check("mem_wdata", bus.mem_wdata, ref_wdata(f3, wdata));
            check("busy_resp_valid", 32'(bus.resp_valid), 32'd0);
            check("busy", 32'(bus.busy), 32'd1);
            scramble_req();
            if (k == ack_at) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = rdata;
                acked         = 1'b1;
            end else begin
                bus.mem_rdata = $urandom;
            end
            @(negedge clk);
            bus.mem_ack = 1'b0;
        end
        bus.req_valid = 1'b0;
        check("resp_mem_req", 32'(bus.mem_req), 32'd0);
        check("resp_valid", 32'(bus.resp_valid), 32'd1);
        check("resp_err", 32'(bus.resp_err), acked ? 32'd0 : 32'd1);
        check("resp_rdata", bus.resp_rdata, (acked && !we) ? ref_load(f3, addr, rdata) : 32'd0);
        check("resp_rd", 32'(bus.resp_rd), (acked && !we) ? 32'(rd) : 32'd0);
    endtask

    initial begin
        bus.req_valid  = 1'b1;   // must not be accepted while in reset
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd2;
        bus.req_addr   = 32'h40;
        bus.req_wdata  = '0;
        bus.req_rd     = 5'd1;
        bus.mem_rdata  = '0;
        bus.mem_ack    = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_be", 32'(bus.mem_be), 32'd0);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(bus.req_ready), 32'd1);
        check("post_rst_mem_req", 32'(bus.mem_req), 32'd0);

        // directed cases
        do_access(1'b0, 3'd2, 32'h0000_0100, 32'h0, 5'd5, 0, 32'hDEAD_BEEF);   // LW
        do_access(1'b0, 3'd0, 32'h0000_0103, 32'h0, 5'd6, 0, 32'h80FF_1234);   // LB
        do_access(1'b0, 3'd4, 32'h0000_0103, 32'h0, 5'd7, 1, 32'h80FF_1234);   // LBU
        do_access(1'b0, 3'd1, 32'h0000_0102, 32'h0, 5'd8, 0, 32'h80FF_1234);   // LH
        do_access(1'b0, 3'd5, 32'h0000_0102, 32'h0, 5'd9, 2, 32'h80FF_1234);   // LHU
        do_access(1'b1, 3'd0, 32'h0000_0201, 32'h1234_56AB, 5'd3, 0, 32'h0);  // SB
        do_access(1'b1, 3'd1, 32'h0000_0202, 32'h0000_1234, 5'd3, 1, 32'h0);  // SH
        do_access(1'b0, 3'd2, 32'h0000_0102, 32'h0, 5'd4, 0, 32'h0);           // misaligned LW
        do_access(1'b1, 3'd1, 32'h0000_0301, 32'h0, 5'd4, 0, 32'h0);           // misaligned SH
        do_access(1'b0, 3'd3, 32'h0000_0100, 32'h0, 5'd4, 0, 32'h0);           // invalid load
        do_access(1'b1, 3'd3, 32'h0000_0100, 32'h0, 5'd4, 0, 32'h0);           // invalid store
        do_access(1'b0, 3'd2, 32'h0000_0200, 32'h0, 5'd10, -1, 32'h0);         // timeout
        do_access(1'b0, 3'd2, 32'h0000_0200, 32'h0, 5'd11, MAXW - 1, 32'h1357_9BDF); // last-cycle ack
        do_access(1'b1, 3'd2, 32'hFFFF_FFFC, 32'hCAFE_F00D, 5'd2, 0, 32'h0);   // top word

        // reset while an access is outstanding
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd2;
        bus.req_addr   = 32'h0000_0400;
        bus.req_rd     = 5'd12;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("pre_rst_mem_req", 32'(bus.mem_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_mem_req", 32'(bus.mem_req), 32'd0);
        check("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
        rst = 1'b0;
        bus.mem_ack = 1'b1;              // stale ack after abort, must be ignored
        @(negedge clk);
        bus.mem_ack = 1'b0;
        check("abort_ready", 32'(bus.req_ready), 32'd1);
        check("abort_no_resp", 32'(bus.resp_valid), 32'd0);
        do_access(1'b0, 3'd2, 32'h0000_0100, 32'h0, 5'd5, 0, 32'h0BAD_F00D);

        // randomized accesses
        for (int n = 0; n < 200; n++) begin
            logic [2:0] f3;
            logic       we;
            logic [31:0] addr;
            int         ack_at;
            we   = 1'($urandom);
            f3   = 3'($urandom);
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;   // bias toward aligned
            ack_at = $urandom_range(0, MAXW);
            if (ack_at == MAXW) ack_at = -1;
            do_access(we, f3, addr, $urandom, 5'($urandom), ack_at, $urandom);
        end

        @(negedge clk);
        check("final_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("final_ready", 32'(bus.req_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
